// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that applies one requester's SR command per cycle to a shared flag bank.
// Define SR_TOGGLE_EN to make op=11 a JK-style toggle instead of an illegal command.
module sr_flag_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned NFLAGS = 8,
  parameter int unsigned IW     = 3,
  parameter int unsigned RW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAGS-1:0]    q,
  output logic                 err,
  output logic [RW-1:0]        err_id,
  output logic [7:0]           err_cnt
);

  logic [1:0]        op_a  [NREQ];
  logic [IW-1:0]     idx_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i]  = op[2*i +: 2];
    assign idx_a[i] = idx[IW*i +: IW];
  end

  logic [NREQ-1:0]   gnt_q, gnt_d, eligible;
  logic [NFLAGS-1:0] q_q, q_d;
  logic [RW-1:0]     ptr_q, ptr_d, win, cand_id, err_id_q, err_id_d;
  logic              found, err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [1:0]        win_op;
  logic [IW-1:0]     win_idx;
  int unsigned       cand;

  // A requester granted last cycle still shows req high, so it sits out one cycle.
  always_comb begin
    eligible = req & ~gnt_q;
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_id  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {{(32-RW){1'b0}}, ptr_q} + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = RW'(cand);
      if (!found && eligible[cand_id]) begin
        found = 1'b1;
        win   = cand_id;
      end
    end
  end

  assign win_op  = op_a[win];
  assign win_idx = idx_a[win];

  always_comb begin
    gnt_d     = '0;
    ptr_d     = ptr_q;
    q_d       = q_q;
    err_d     = 1'b0;
    err_id_d  = err_id_q;
    err_cnt_d = err_cnt_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      ptr_d      = (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
      case (win_op)
        2'b01: q_d[win_idx] = 1'b0;
        2'b10: q_d[win_idx] = 1'b1;
        2'b11: begin
`ifdef SR_TOGGLE_EN
          q_d[win_idx] = ~q_q[win_idx];
`else
          err_d     = 1'b1;
          err_id_d  = win;
          err_cnt_d = (err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q     <= '0;
      ptr_q     <= '0;
      q_q       <= '0;
      err_q     <= 1'b0;
      err_id_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      q_q       <= q_d;
      err_q     <= err_d;
      err_id_q  <= err_id_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign err     = err_q;
  assign err_id  = err_id_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Bank of NFLAGS SR flip-flop state bits shared by NREQ requesters.
- Each requester issues one SR command per transaction: hold, reset, set, or illegal S=R=1.
- A registered round-robin arbiter grants one requester per cycle and applies its command to the addressed flag bit.
- Sits between control agents and the status/flag register; it is the sole writer of the flag bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NFLAGS, 8, number of SR flag bits (power of two, 2..64).
- IW, 3, flag index width; must equal log2(NFLAGS).
- RW, 2, requester id width; must equal log2(NREQ), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; held high until granted.
- op  input  2*NREQ  per-requester command, slice [2i+1:2i] = {s,r}; 00 hold, 01 reset, 10 set, 11 illegal.
- idx  input  IW*NREQ  per-requester flag index, slice [IW*i+IW-1:IW*i].
- gnt  output  NREQ  one-hot, one-cycle grant pulse (registered).
- q  output  NFLAGS  flag bank state.
- err  output  1  one-cycle pulse: the granted command was op=11 (SR_TOGGLE_EN undefined only).
- err_id  output  RW  requester id of the last err; holds its value until the next err.
- err_cnt  output  8  saturating count of err pulses.

Behaviour:
- Reset (rst=1 at a clk edge): q=0, gnt=0, err=0, err_id=0, err_cnt=0, round-robin pointer ptr=0. Reset has priority over every other action, including an in-flight grant; the command presented in that cycle is discarded.
- Each cycle the arbiter evaluates eligible = req & ~gnt. A requester granted this cycle is excluded, because it still sees req high while observing gnt.
- Winner: the first eligible requester searching from ptr upward, modulo NREQ.
- At the next edge, with a winner w:
  - gnt = one-hot(w), and ptr = (w+1) mod NREQ.
  - The command op[w] is applied to q[idx[w]] at the same edge.
- With no winner: gnt=0 and ptr is unchanged.
- Latency: req sampled in cycle t; gnt and the q update both become visible in cycle t+1.
- Handshake: the requester samples gnt=1 and then drops req, or presents a new command, in that same cycle. The earliest re-grant to the same requester is cycle t+2.
- Command semantics on q[k], k=idx[w]:
  - 00: q[k] unchanged (grant still issued).
  - 01: q[k]=0.
  - 10: q[k]=1.
  - 11: q[k] unchanged; err=1, err_id=w, err_cnt += 1 saturating at 255.
- Only one bit of q can change per cycle, so set and reset to the same bit in the same cycle cannot occur.
- Non-granted requests have no effect on q.
- err, err_id and err_cnt are only updated on a granted op=11.
- Round-robin guarantee: with all NREQ requesting continuously, each requester is granted at least once in every 2*NREQ cycles. No starvation.

Optional Feature:
- Macro: SR_TOGGLE_EN.
- Defined: op=11 inverts q[idx] (JK-style toggle); err never asserts; err_id and err_cnt stay at reset values.
- Undefined: op=11 behaves as an illegal command, as described in Behaviour.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles with all req=1.
  - Required: q=00, gnt=0, err_cnt=0.
  - Then, after rst=0, the first gnt is 0001.
- Set/reset single requester:
  - Stimulus: req0, op=10, idx=5.
  - Required: the next cycle shows gnt=0001 and q=0x20.
  - Follow-up: op=01, idx=5 gives q=0x00.
- Round-robin:
  - Stimulus: req=1111 held for 8 cycles, all op=00.
  - Required: gnt sequence 0001, 0010, 0100, 1000, repeating. Pattern 0001 never appears twice in consecutive cycles.
- Contention on one bit:
  - Stimulus: req0 op=10 idx=2 together with req1 op=01 idx=2, both asserted in the same cycle with ptr=0.
  - Required: q[2]=1, then q[2]=0 on the following grant.
- Illegal op:
  - Stimulus: req2 op=11 idx=3 with q[3]=1, build without SR_TOGGLE_EN.
  - Required: q[3] stays 1, err pulses for 1 cycle, err_id=2, err_cnt=1.
  - Same stimulus with SR_TOGGLE_EN defined: q[3]=0 and err=0.
- Reset mid-operation:
  - Stimulus: rst=1 in the same cycle a grant for op=10 idx=7 would occur.
  - Required: q[7]=0, gnt=0, ptr=0.
